// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the transmitter state encoding, frame data width and default bit period.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the upstream synchronous FIFO and the UART transmitter.
// master = transmitter (pops), slave = FIFO (supplies empty flag and data).
interface fifo_uart_tx_if;
  import uart_pkg::*;

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
// The owner clears it on every state change so each state starts a fresh period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = enable && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops one byte per frame from an upstream synchronous FIFO.
// Frame sequence: IDLE (pop) -> FETCH (capture) -> START -> 8 x DATA (LSB first) -> STOP.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 tx_q;
  logic                 busy_q;
  logic [15:0]          frames_q;

  logic rd_en_s;
  logic timing_s;
  logic clear_s;
  logic bit_done_s;

  // Pop request: only from IDLE, and never while reset is held
  always_comb begin
    rd_en_s = 1'b0;
    if ((state_q == ST_IDLE) && tx_en && !fifo.fifo_empty && !reset) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Baud timer runs only in line-driving states; bit_done also restarts the period
  always_comb begin
    timing_s = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    clear_s  = !timing_s || bit_done_s;
  end

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .enable   (timing_s),
    .bit_done (bit_done_s)
  );

  // Frame sequencer with registered line, busy flag and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      frames_q  <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (rd_en_s) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          shift_q   <= fifo.fifo_dout;
          bit_idx_q <= 3'd0;
          state_q   <= ST_START;
          tx_q      <= 1'b0;
        end
        ST_START: begin
          if (bit_done_s) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            if (bit_idx_q == LAST_BIT) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              // The line takes the next bit as the shifter moves it into bit 0
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            frames_q <= frames_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.fifo_rd_en = rd_en_s;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign frames_sent     = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx at CLKS_PER_BIT=4 with a registered-dout FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  fifo_uart_tx_if fifo_if ();

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_en       (tx_en),
    .fifo        (fifo_if),
    .tx          (tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: 16-deep memory, data appears on the cycle after the pop
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  int cyc    = 0;

  assign fifo_if.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_if.fifo_rd_en) begin
      fifo_if.fifo_dout <= mem[rd_ptr[3:0]];
      rd_ptr            <= rd_ptr + 1;
      pops              <= pops + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for tx to go low; returns the cycle index of the first start-bit sample
  task automatic wait_start(input string tag, output int t);
    bit seen;
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        t    = cyc;
      end
    end
    check_eq({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  // Samples one frame every cycle from the first start-bit sample; act 1 drops tx_en and pushes 0x66
  task automatic rx_frame(input int act_at, input int act, output logic [7:0] data, output logic ok);
    logic [9:0] bits;
    logic       s;
    ok   = 1'b1;
    bits = '0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i > 0) @(negedge clk);
      s = tx;
      if ((i % CPB) == 0) begin
        bits[i / CPB] = s;
      end else if (s !== bits[i / CPB]) begin
        ok = 1'b0;
      end
      if (i == act_at && act == 1) begin
        tx_en = 1'b0;
        push(8'h66);
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    data = bits[8:1];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         t0, s1, s2, s3, p0;
    logic [7:0] d;
    logic       ok;
    bit         bad;

    reset = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_if.fifo_rd_en), 32'd0);
    check_eq("rst_frames", 32'(frames_sent), 32'd0);

    // Empty FIFO with tx_en high: nothing happens for 50 cycles
    reset = 1'b0;
    tx_en = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_if.fifo_rd_en !== 1'b0) bad = 1'b1;
    end
    check_eq("empty_idle50", 32'(bad), 32'd0);
    check_eq("empty_frames", 32'(frames_sent), 32'd0);

    // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1
    p0 = pops;
    push(8'hA5);
    t0 = cyc;
    #1;
    check_eq("a5_rd_en", 32'(fifo_if.fifo_rd_en), 32'd1);
    wait_start("a5", s1);
    check_eq("a5_latency", 32'(s1 - t0), 32'd2);
    rx_frame(-1, 0, d, ok);
    check_eq("a5_data", 32'(d), 32'hA5);
    check_eq("a5_shape", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("a5_frames", 32'(frames_sent), 32'd1);
    check_eq("a5_busy", 32'(busy), 32'd0);
    check_eq("a5_pops", 32'(pops - p0), 32'd1);

    // Three back-to-back frames, 42 cycles start to start
    pulse_reset();
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_start("b0", s1);
    rx_frame(-1, 0, d, ok);
    check_eq("b0_data", 32'(d), 32'h00);
    check_eq("b0_shape", 32'(ok), 32'd1);
    wait_start("b1", s2);
    rx_frame(-1, 0, d, ok);
    check_eq("b1_data", 32'(d), 32'hFF);
    check_eq("b1_shape", 32'(ok), 32'd1);
    check_eq("b01_period", 32'(s2 - s1), 32'd42);
    wait_start("b2", s3);
    rx_frame(-1, 0, d, ok);
    check_eq("b2_data", 32'(d), 32'h3C);
    check_eq("b2_shape", 32'(ok), 32'd1);
    check_eq("b12_period", 32'(s3 - s2), 32'd42);
    @(negedge clk);
    check_eq("b_frames", 32'(frames_sent), 32'd3);
    check_eq("b_pops", 32'(pops - p0), 32'd3);
    check_eq("b_fifo_empty", 32'(fifo_if.fifo_empty), 32'd1);

    // tx_en drops during data bit 3 of 0x55; 0x66 waits until re-enabled
    pulse_reset();
    p0 = pops;
    push(8'h55);
    wait_start("c0", s1);
    rx_frame(17, 1, d, ok);
    check_eq("c0_data", 32'(d), 32'h55);
    check_eq("c0_shape", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("c0_frames", 32'(frames_sent), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_if.fifo_rd_en !== 1'b0) bad = 1'b1;
    end
    check_eq("c_hold_idle", 32'(bad), 32'd0);
    check_eq("c_hold_pops", 32'(pops - p0), 32'd1);
    tx_en = 1'b1;
    #1;
    check_eq("c1_rd_en", 32'(fifo_if.fifo_rd_en), 32'd1);
    wait_start("c1", s2);
    rx_frame(-1, 0, d, ok);
    check_eq("c1_data", 32'(d), 32'h66);
    check_eq("c1_shape", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("c1_frames", 32'(frames_sent), 32'd2);
    check_eq("c1_pops", 32'(pops - p0), 32'd2);

    // Reset during data bit 5 of 0x81 aborts the frame
    pulse_reset();
    push(8'h81);
    wait_start("d0", s1);
    repeat (25) @(negedge clk);
    check_eq("d0_bit5_low", 32'(tx), 32'd0);
    check_eq("d0_busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("d0_abort_tx", 32'(tx), 32'd1);
    check_eq("d0_abort_busy", 32'(busy), 32'd0);
    check_eq("d0_abort_frames", 32'(frames_sent), 32'd0);
    check_eq("d0_abort_rd_en", 32'(fifo_if.fifo_rd_en), 32'd0);
    reset = 1'b0;
    p0 = pops;
    push(8'h7E);
    wait_start("d1", s2);
    rx_frame(-1, 0, d, ok);
    check_eq("d1_data", 32'(d), 32'h7E);
    check_eq("d1_shape", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("d1_frames", 32'(frames_sent), 32'd1);
    check_eq("d1_pops", 32'(pops - p0), 32'd1);
    check_eq("d1_fifo_empty", 32'(fifo_if.fifo_empty), 32'd1);

    // Frame counter wraps from 0xFFFF to 0x0000
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    @(negedge clk);
    check_eq("e_preload", 32'(frames_sent), 32'h0000FFFF);
    push(8'hC3);
    wait_start("e0", s1);
    rx_frame(-1, 0, d, ok);
    check_eq("e0_data", 32'(d), 32'hC3);
    @(negedge clk);
    check_eq("e0_wrap", 32'(frames_sent), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
